// File: rtl/max7219_frame_writer.sv
// Writes six BCD stopwatch digits to a MAX7219 over a 3-wire SPI link: init sequence, then refresh frames.
// Optional macro LEADING_ZERO_BLANK_EN: blanks the tens-of-minutes digit when it is zero.
module max7219_frame_writer #(
   parameter int         CLK_DIV   = 4,
   parameter logic [3:0] INTENSITY = 4'h8
) (
   input  logic       clk,
   input  logic       res,
   input  logic       ena,
   input  logic [2:0] min_X0,
   input  logic [3:0] min_0X,
   input  logic [2:0] sec_X0,
   input  logic [3:0] sec_0X,
   input  logic [3:0] ces_X0,
   input  logic [3:0] ces_0X,
   output logic       mosi,
   output logic       cs,
   output logic       sck,
   output logic       busy,
   output logic       init_done
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_FRAME = 2'd2
   } state_t;

   localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
   localparam logic [5:0] PH_LAST = 6'd33;

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic       run_q, run_d;
   logic [5:0] ph_q, ph_d;
   logic [7:0] div_q, div_d;
   logic [2:0] snap_m10_q, snap_m10_d;
   logic [3:0] snap_m1_q, snap_m1_d;
   logic [2:0] snap_s10_q, snap_s10_d;
   logic [3:0] snap_s1_q, snap_s1_d;
   logic [3:0] snap_c10_q, snap_c10_d;
   logic [3:0] snap_c1_q, snap_c1_d;
   logic       init_done_q, init_done_d;
   logic       cs_q, cs_d;
   logic       sck_q, sck_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic [2:0] last_idx_s;
   logic [7:0] data_s;
   logic [15:0] word_s;
   logic        shifting_s;

   // State register and all registered outputs
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q     <= ST_INIT;
         idx_q       <= 3'd0;
         run_q       <= 1'b0;
         ph_q        <= 6'd0;
         div_q       <= 8'd0;
         snap_m10_q  <= 3'd0;
         snap_m1_q   <= 4'd0;
         snap_s10_q  <= 3'd0;
         snap_s1_q   <= 4'd0;
         snap_c10_q  <= 4'd0;
         snap_c1_q   <= 4'd0;
         init_done_q <= 1'b0;
         cs_q        <= 1'b1;
         sck_q       <= 1'b0;
         mosi_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         run_q       <= run_d;
         ph_q        <= ph_d;
         div_q       <= div_d;
         snap_m10_q  <= snap_m10_d;
         snap_m1_q   <= snap_m1_d;
         snap_s10_q  <= snap_s10_d;
         snap_s1_q   <= snap_s1_d;
         snap_c10_q  <= snap_c10_d;
         snap_c1_q   <= snap_c1_d;
         init_done_q <= init_done_d;
         cs_q        <= cs_d;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
         busy_q      <= busy_d;
      end
   end

   // Sequencer: ph counts 34 half-periods per word (32 shifting, 2 with cs high)
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      run_d       = run_q;
      ph_d        = ph_q;
      div_d       = div_q;
      snap_m10_d  = snap_m10_q;
      snap_m1_d   = snap_m1_q;
      snap_s10_d  = snap_s10_q;
      snap_s1_d   = snap_s1_q;
      snap_c10_d  = snap_c10_q;
      snap_c1_d   = snap_c1_q;
      init_done_d = init_done_q;
      last_idx_s  = (state_q == ST_INIT) ? 3'd4 : 3'd5;
      case (state_q)
         ST_IDLE: begin
            if (ena) begin
               state_d    = ST_FRAME;
               idx_d      = 3'd0;
               run_d      = 1'b1;
               ph_d       = 6'd0;
               div_d      = 8'd0;
               snap_m10_d = min_X0;
               snap_m1_d  = min_0X;
               snap_s10_d = sec_X0;
               snap_s1_d  = sec_0X;
               snap_c10_d = ces_X0;
               snap_c1_d  = ces_0X;
            end else begin
               run_d = 1'b0;
            end
         end
         ST_INIT, ST_FRAME: begin
            if (!run_q) begin
               run_d = 1'b1;
               ph_d  = 6'd0;
               div_d = 8'd0;
            end else if (div_q != DIV_MAX) begin
               div_d = div_q + 8'd1;
            end else if (ph_q != PH_LAST) begin
               div_d = 8'd0;
               ph_d  = ph_q + 6'd1;
            end else begin
               div_d = 8'd0;
               ph_d  = 6'd0;
               if (idx_q == last_idx_s) begin
                  init_done_d = init_done_q | (state_q == ST_INIT);
                  state_d     = ST_IDLE;
                  idx_d       = 3'd0;
                  run_d       = 1'b0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
            idx_d   = 3'd0;
            run_d   = 1'b0;
         end
      endcase
   end

   // Word to transmit, selected from the next-state position so outputs register in step
   always_comb begin
      data_s = 8'h00;
      case (idx_d)
         3'd0: data_s = {4'h0, snap_c1_d};
         3'd1: data_s = {4'h0, snap_c10_d};
         3'd2: data_s = {4'h8, snap_s1_d};
         3'd3: data_s = {5'b00000, snap_s10_d};
         3'd4: data_s = {4'h8, snap_m1_d};
`ifdef LEADING_ZERO_BLANK_EN
         3'd5: data_s = (snap_m10_d == 3'd0) ? 8'h0F : {5'b00000, snap_m10_d};
`else
         3'd5: data_s = {5'b00000, snap_m10_d};
`endif
         default: data_s = 8'h00;
      endcase
      word_s = 16'h0000;
      if (state_d == ST_INIT) begin
         case (idx_d)
            3'd0: word_s = 16'h0C01;
            3'd1: word_s = 16'h0F00;
            3'd2: word_s = 16'h093F;
            3'd3: word_s = 16'h0B05;
            3'd4: word_s = {12'h0A0, INTENSITY};
            default: word_s = 16'h0000;
         endcase
      end else begin
         word_s = {5'b00000, idx_d + 3'd1, data_s};
      end
   end

   // SPI pin decode: sck high on odd half-periods, mosi steps one bit per sck period
   always_comb begin
      shifting_s = run_d && !ph_d[5];
      cs_d       = !shifting_s;
      sck_d      = shifting_s && ph_d[0];
      mosi_d     = shifting_s ? word_s[4'd15 - ph_d[4:1]] : 1'b0;
      busy_d     = (state_d != ST_IDLE);
   end

   assign mosi      = mosi_q;
   assign cs        = cs_q;
   assign sck       = sck_q;
   assign busy      = busy_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_max7219_frame_writer.sv
// Directed bench for max7219_frame_writer: decodes SPI words at the pins and checks them against hand values.
module tb_max7219_frame_writer;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic       ena = 1'b0;
   logic [2:0] min_X0 = 3'd0;
   logic [3:0] min_0X = 4'd0;
   logic [2:0] sec_X0 = 3'd0;
   logic [3:0] sec_0X = 4'd0;
   logic [3:0] ces_X0 = 4'd0;
   logic [3:0] ces_0X = 4'd0;
   logic       mosi, cs, sck, busy, init_done;

   int checks = 0;
   int errors = 0;

   logic [15:0] wq[$];
   int          pq[$];
   int          tim_err = 0;

   int          cyc = 0;
   int          t0 = 0;
   int          last_rise = 0;
   int          last_cs_rise = -1000;
   int          nsck = 0;
   logic [15:0] sh = 16'h0000;
   bit          in_word = 1'b0;
   logic        prev_cs = 1'b1;
   logic        prev_sck = 1'b0;

   max7219_frame_writer #(.CLK_DIV(CLK_DIV), .INTENSITY(4'h8)) dut (
      .clk(clk), .res(res), .ena(ena),
      .min_X0(min_X0), .min_0X(min_0X), .sec_X0(sec_X0), .sec_0X(sec_0X),
      .ces_X0(ces_X0), .ces_0X(ces_0X),
      .mosi(mosi), .cs(cs), .sck(sck), .busy(busy), .init_done(init_done)
   );

   always #5 clk = ~clk;

   // Pin-level SPI decoder, sampled on the inactive clock edge
   always @(negedge clk) begin
      cyc++;
      if (res) begin
         in_word      = 1'b0;
         last_cs_rise = -1000;
      end else begin
         if (!cs && prev_cs) begin
            if (cyc - last_cs_rise < 2 * CLK_DIV) tim_err++;
            in_word   = 1'b1;
            t0        = cyc;
            sh        = 16'h0000;
            nsck      = 0;
            last_rise = cyc - CLK_DIV;
         end
         if (in_word && sck && !prev_sck) begin
            sh = {sh[14:0], mosi};
            nsck++;
            if (cyc - last_rise != 2 * CLK_DIV) tim_err++;
            last_rise = cyc;
         end
         if (in_word && !sck && prev_sck && (cyc - last_rise != CLK_DIV)) tim_err++;
         if (cs && !prev_cs && in_word) begin
            in_word = 1'b0;
            if (cyc - t0 != 32 * CLK_DIV) tim_err++;
            if (sck !== 1'b0) tim_err++;
            wq.push_back(sh);
            pq.push_back(nsck);
            last_cs_rise = cyc;
         end
         if (cs && mosi !== 1'b0) tim_err++;
      end
      prev_cs  = cs;
      prev_sck = sck;
   end

   task automatic wait_words(input int n, input int budget);
      int k;
      k = 0;
      while (wq.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      checks++;
      if (wq.size() < n) begin
         errors++;
         $display("FAIL wait_words got %0d words expected %0d", wq.size(), n);
      end
   endtask

   function automatic logic [15:0] pop_word();
      logic [15:0] w;
      w = 16'hDEAD;
      if (wq.size() > 0) w = wq.pop_front();
      return w;
   endfunction

   task automatic set_digits(input logic [2:0] m10, input logic [3:0] m1, input logic [2:0] s10,
                             input logic [3:0] s1, input logic [3:0] c10, input logic [3:0] c1);
      min_X0 = m10; min_0X = m1; sec_X0 = s10; sec_0X = s1; ces_X0 = c10; ces_0X = c1;
   endtask

   task automatic test_reset();
      res = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b expected 1", cs); end
      checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b expected 0", sck); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b expected 0", mosi); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b expected 0", init_done); end
   endtask

   task automatic test_init();
      logic [15:0] exp [5] = '{16'h0C01, 16'h0F00, 16'h093F, 16'h0B05, 16'h0A08};
      logic [15:0] got;
      int p;
      @(posedge clk); #2 res = 1'b0;
      wait_words(4, 2000);
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early got %b expected 0", init_done); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy_gap got %b expected 1", busy); end
      wait_words(5, 1000);
      repeat (12) @(posedge clk);
      #1;
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b expected 1", init_done); end
      for (int i = 0; i < 5; i++) begin
         got = pop_word();
         p = (pq.size() > 0) ? pq.pop_front() : -1;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL init_word%0d got %h expected %h", i, got, exp[i]); end
         checks++; if (p != 16) begin errors++; $display("FAIL init_sck_pulses%0d got %0d expected 16", i, p); end
      end
      repeat (300) @(posedge clk);
      #1;
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL idle_no_words got %0d expected 0", wq.size()); end
      checks++; if (busy !== 1'b0 || cs !== 1'b1) begin errors++; $display("FAIL idle_pins got busy=%b cs=%b expected busy=0 cs=1", busy, cs); end
   endtask

   task automatic test_frame();
      logic [15:0] exp [6] = '{16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0582, 16'h0601};
      logic [15:0] got;
      set_digits(3'd1, 4'd2, 3'd3, 4'd4, 4'd5, 4'd6);
      ena = 1'b1;
      wait_words(1, 1000);
      ena = 1'b0;
      wait_words(6, 2000);
      repeat (300) @(posedge clk);
      #1;
      checks++; if (wq.size() != 6) begin errors++; $display("FAIL frame_count got %0d expected 6", wq.size()); end
      for (int i = 0; i < 6; i++) begin
         got = pop_word();
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL frame_word%0d got %h expected %h", i, got, exp[i]); end
      end
      pq.delete();
   endtask

   task automatic test_snapshot();
      logic [15:0] exp [12] = '{16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0582, 16'h0601,
                                16'h010F, 16'h0208, 16'h0387, 16'h0400, 16'h0589, 16'h0605};
      logic [15:0] got;
      set_digits(3'd1, 4'd2, 3'd3, 4'd4, 4'd5, 4'd6);
      ena = 1'b1;
      wait_words(3, 2000);
      set_digits(3'd5, 4'd9, 3'd0, 4'd7, 4'd8, 4'd15);
      wait_words(7, 2000);
      ena = 1'b0;
      wait_words(12, 2000);
      repeat (300) @(posedge clk);
      #1;
      checks++; if (wq.size() != 12) begin errors++; $display("FAIL snap_count got %0d expected 12", wq.size()); end
      for (int i = 0; i < 12; i++) begin
         got = pop_word();
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL snap_word%0d got %h expected %h", i, got, exp[i]); end
      end
      pq.delete();
   endtask

   task automatic test_ena_drop();
      logic [15:0] got;
      set_digits(3'd1, 4'd2, 3'd3, 4'd4, 4'd5, 4'd6);
      ena = 1'b1;
      wait_words(2, 2000);
      repeat (20) @(posedge clk);
      #2 ena = 1'b0;
      wait_words(6, 2000);
      repeat (400) @(posedge clk);
      #1;
      checks++; if (wq.size() != 6) begin errors++; $display("FAIL drop_count got %0d expected 6", wq.size()); end
      checks++; if (busy !== 1'b0 || cs !== 1'b1) begin errors++; $display("FAIL drop_idle got busy=%b cs=%b expected busy=0 cs=1", busy, cs); end
      for (int i = 0; i < 5; i++) got = pop_word();
      got = pop_word();
      checks++; if (got !== 16'h0601) begin errors++; $display("FAIL drop_last got %h expected 0601", got); end
      ena = 1'b1;
      wait_words(1, 1000);
      ena = 1'b0;
      got = pop_word();
      checks++; if (got !== 16'h0106) begin errors++; $display("FAIL drop_restart got %h expected 0106", got); end
      wait_words(5, 2000);
      repeat (20) @(posedge clk);
      wq.delete();
      pq.delete();
   endtask

   task automatic test_reset_mid();
      logic [15:0] exp [5] = '{16'h0C01, 16'h0F00, 16'h093F, 16'h0B05, 16'h0A08};
      logic [15:0] got;
      int k;
      ena = 1'b1;
      k = 0;
      while (cs !== 1'b0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      repeat (20) @(posedge clk);
      #2 res = 1'b1;
      #1;
      checks++; if (cs !== 1'b1) begin errors++; $display("FAIL midreset_cs got %b expected 1", cs); end
      checks++; if (init_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_flags got init_done=%b busy=%b expected 0 0", init_done, busy); end
      @(posedge clk); #2 res = 1'b0;
      wq.delete();
      pq.delete();
      wait_words(6, 3000);
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         got = pop_word();
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL rerun_word%0d got %h expected %h", i, got, exp[i]); end
      end
      got = pop_word();
      checks++; if (got !== 16'h0106) begin errors++; $display("FAIL rerun_frame got %h expected 0106", got); end
      wait_words(5, 2000);
      repeat (20) @(posedge clk);
      wq.delete();
      pq.delete();
   endtask

   task automatic test_blank();
      logic [15:0] got;
      logic [15:0] exp6;
`ifdef LEADING_ZERO_BLANK_EN
      exp6 = 16'h060F;
`else
      exp6 = 16'h0600;
`endif
      set_digits(3'd0, 4'd7, 3'd2, 4'd1, 4'd0, 4'd9);
      ena = 1'b1;
      wait_words(1, 1000);
      ena = 1'b0;
      wait_words(6, 2000);
      for (int i = 0; i < 4; i++) got = pop_word();
      got = pop_word();
      checks++; if (got !== 16'h0587) begin errors++; $display("FAIL blank_word5 got %h expected 0587", got); end
      got = pop_word();
      checks++; if (got !== exp6) begin errors++; $display("FAIL blank_word6 got %h expected %h", got, exp6); end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_timing();
      #1;
      checks++; if (tim_err != 0) begin errors++; $display("FAIL spi_timing got %0d violations expected 0", tim_err); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_frame();
      test_snapshot();
      test_ena_drop();
      test_reset_mid();
      test_blank();
      test_timing();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/max7219_frame_writer.md
Name: max7219_frame_writer

Overview:
- Downstream stage of the stopwatch counter chain: takes six BCD digits and writes them to a MAX7219 7-segment driver over a 3-wire SPI link.
- After reset it runs the MAX7219 init sequence, then sends refresh frames (6 digit-register writes) while `ena` is high.
- Digits are snapshotted at each frame start, so one frame never mixes two counter values.
- `ena` low freezes the display, which gives the lap-time function.

Parameters:
- CLK_DIV, 4, clk cycles per SPI half-period; sck = clk/(2*CLK_DIV); legal range 1..255.
- INTENSITY, 4'h8, value written to MAX7219 intensity register 0x0A.

Ports:
- clk  input  1  system clock
- res  input  1  asynchronous, active-high reset
- ena  input  1  display enable; 1 = refresh frames run, 0 = hold display
- min_X0  input  3  tens of minutes (0-5)
- min_0X  input  4  units of minutes
- sec_X0  input  3  tens of seconds (0-5)
- sec_0X  input  4  units of seconds
- ces_X0  input  4  tenths
- ces_0X  input  4  hundredths
- mosi  output  1  SPI data, MSB first
- cs  output  1  SPI chip select (LOAD), active low
- sck  output  1  SPI clock, idle low
- busy  output  1  high while a word is in progress or while between words of a sequence
- init_done  output  1  high once the init sequence has completed

Behaviour:
- Reset (async, `res`=1) gives: cs=1, sck=0, mosi=0, busy=0, init_done=0, FSM=INIT, word index=0. Reset mid-word aborts immediately (cs forced high); the full init sequence reruns.
- FSM states: INIT -> IDLE -> FRAME -> IDLE.
  - INIT starts on the first clk edge after `res` falls.
  - INIT sends 5 words in order: 0x0C01 (shutdown off), 0x0F00 (display test off), 0x093F (code-B decode on digits 0-5), 0x0B05 (scan limit 6 digits), 0x0A0 followed by the INTENSITY nibble (intensity).
  - After INIT, init_done=1 and the FSM goes to IDLE.
- IDLE: if ena=1, on the next clk the FSM latches all six digit inputs into a snapshot and enters FRAME. If ena=0, it stays in IDLE with cs=1.
- FRAME sends 6 words, register address then data:
  - 0x01 with ces_0X
  - 0x02 with ces_X0
  - 0x03 with {1'b1, sec_0X} (DP on)
  - 0x04 with sec_X0
  - 0x05 with {1'b1, min_0X} (DP on)
  - 0x06 with min_X0
  - Data byte = {DP, 3'b000, digit}. 3-bit inputs are zero-extended.
  - After the last word: back to IDLE. Frames repeat back-to-back while ena stays 1.
- Word timing, with cs falling at cycle t:
  - mosi = bit15 at cycle t.
  - sck rises at t+CLK_DIV and falls at t+2*CLK_DIV; mosi shifts to the next bit on each falling edge.
  - The 16th falling edge occurs at t+32*CLK_DIV; cs rises in that same cycle, and mosi returns to 0.
  - cs stays high for at least 2*CLK_DIV cycles before the next word.
  - One word occupies 34*CLK_DIV cycles.
- ena going low mid-frame: the current frame completes, then the FSM idles, so the display always shows one coherent snapshot. ena is ignored during INIT.
- Digit inputs are not checked for range: a value >9 is transmitted unchanged (code-B decoding shows it as a symbol or blank).
- busy=1 from the first cycle of INIT/FRAME through the final cs rise, and 0 in IDLE.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: when min_X0==0 in the snapshot, register 0x06 is written with data 0x0F (code-B blank) instead of 0x00.
- Undefined: min_X0 is always sent as-is; a leading zero is displayed.

Test Plan:
- Hold res=1, then check outputs -> cs=1, sck=0, mosi=0, busy=0, init_done=0. Release res with CLK_DIV=4 -> decoded words are 0x0C01, 0x0F00, 0x093F, 0x0B05, 0x0A08; init_done rises after the 5th word. Check 16 sck pulses per word, each 8 clk cycles.
- ena=1 with digits 1,2:3,4.5,6 (min 12, sec 34, ces 56) -> words are 0x0106, 0x0205, 0x0384, 0x0403, 0x0582, 0x0601.
- Change the digits halfway through a frame -> the rest of that frame still carries the old snapshot; the next frame carries the new values.
- Drop ena to 0 during word 3 of a frame -> words 4-6 still sent, then cs stays high and busy=0 indefinitely; raising ena again restarts frames from register 0x01.
- Assert res for 1 cycle mid-word -> cs goes high asynchronously; the sequence restarts at 0x0C01.
- With LEADING_ZERO_BLANK_EN defined and min_X0=0 -> register 6 word is 0x060F; without the macro it is 0x0600.
